// File: rtl/isa_pipe.sv
// Two-stage ISA datapath (D: operand read/execute, E: commit/output): 2-cycle latency, 1 instr/cycle.
// in_ready drops only when both stages hold work and the consumer stalls; E holds its data until taken.
module isa_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int RAM_AW = 5,
  localparam int INSTR_W = 2*REG_AW + RAM_AW + 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int RB_D  = 1 << REG_AW;
  localparam int RAM_D = 1 << RAM_AW;

  typedef struct packed {
    logic [REG_AW-1:0] op1;
    logic [REG_AW-1:0] op2;
    logic              we_br;
    logic [2:0]        alu_op;
    logic [RAM_AW-1:0] dir;
    logic              we_ram;
  } instr_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RAM_AW-1:0] dir;
    logic [REG_AW-1:0] waddr;
    logic              we_ram;
    logic              we_br;
  } ex_t;

  logic              d_valid_q, d_valid_d;
  instr_t            d_q, d_d;
  logic              e_valid_q, e_valid_d;
  ex_t               e_q, e_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] rb_q  [RB_D];
  logic [DATA_W-1:0] ram_q [RAM_D];

  logic              advance_e, accept, commit;
  logic [DATA_W-1:0] opa, opb, alu_res, rd_val;
  logic [REG_AW-1:0] d_waddr;
  logic [SH_W-1:0]   sh;

  assign advance_e = !e_valid_q || out_ready;
  assign in_ready  = !d_valid_q || advance_e;
  assign accept    = in_valid && in_ready;
  assign commit    = e_valid_q && out_ready;
  assign out_valid = e_valid_q;
  assign out_data  = out_q;

  // E has not committed yet, so its result must override the stale bank/RAM contents.
  always_comb begin
    d_waddr = REG_AW'(d_q.dir);
    opa     = rb_q[d_q.op1];
    opb     = rb_q[d_q.op2];
    rd_val  = ram_q[d_q.dir];
    if (e_valid_q && e_q.we_br && (e_q.waddr == d_q.op1)) opa = e_q.result;
    if (e_valid_q && e_q.we_br && (e_q.waddr == d_q.op2)) opb = e_q.result;
    if (e_valid_q && e_q.we_ram && (e_q.dir == d_q.dir))  rd_val = e_q.result;
    sh = opb[SH_W-1:0];
    case (d_q.alu_op)
      3'd0:    alu_res = opa + opb;
      3'd1:    alu_res = opa - opb;
      3'd2:    alu_res = opa & opb;
      3'd3:    alu_res = opa | opb;
      3'd4:    alu_res = opa ^ opb;
      3'd5:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      3'd6:    alu_res = opa << sh;
      default: alu_res = opa >> sh;
    endcase
  end

  always_comb begin
    d_valid_d = d_valid_q;
    d_d       = d_q;
    e_valid_d = e_valid_q;
    e_d       = e_q;
    out_d     = out_q;
    if (advance_e) begin
      e_valid_d = d_valid_q;
      d_valid_d = 1'b0;
      if (d_valid_q) begin
        e_d.result = alu_res;
        e_d.dir    = d_q.dir;
        e_d.waddr  = d_waddr;
        e_d.we_ram = d_q.we_ram;
        e_d.we_br  = d_q.we_br;
        out_d      = (d_q.we_ram || d_q.we_br) ? alu_res : rd_val;
      end
    end
    if (accept) begin
      d_valid_d = 1'b1;
      d_d       = instr_t'(in_instr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid_q <= 1'b0;
      d_q       <= '0;
      e_valid_q <= 1'b0;
      e_q       <= '0;
      out_q     <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      d_q       <= d_d;
      e_valid_q <= e_valid_d;
      e_q       <= e_d;
      out_q     <= out_d;
    end
  end

  // Architectural state changes only on the output handshake, so a stalled E never re-commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RB_D; i++)  rb_q[REG_AW'(i)]  <= DATA_W'(i);
      for (int i = 0; i < RAM_D; i++) ram_q[RAM_AW'(i)] <= '0;
    end else if (commit) begin
      if (e_q.we_ram) ram_q[e_q.dir] <= e_q.result;
      if (e_q.we_br)  rb_q[e_q.waddr] <= e_q.result;
    end
  end

endmodule

// File: tb/tb_isa_pipe.sv
// Bench for isa_pipe: directed scenarios plus random traffic scored against an in-order ISA model.
module tb_isa_pipe;
  localparam int DW = 32;
  localparam int RA = 5;
  localparam int MA = 5;
  localparam int IW = 2*RA + MA + 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_instr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  isa_pipe #(.DATA_W(DW), .REG_AW(RA), .RAM_AW(MA)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0, fire_cyc = 0;
  logic [DW-1:0] mrb  [32];
  logic [DW-1:0] mram [32];
  logic [IW-1:0] q[$];
  logic [DW-1:0] outs[$];
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  bit            acc;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int o1, input int o2, input int wb,
                                       input int op, input int d, input int wr);
    return {RA'(o1), RA'(o2), 1'(wb), 3'(op), MA'(d), 1'(wr)};
  endfunction

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      3'd6:    return a << (b % DW);
      default: return a >> (b % DW);
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    stall_prev = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mrb[5'(i)]  = DW'(i);
      mram[5'(i)] = '0;
    end
  endtask

  // Executes the oldest instruction against committed state: returns its output, applies its writes.
  task automatic model_commit(output logic [DW-1:0] exp);
    logic [IW-1:0] ins;
    logic [DW-1:0] r;
    logic [MA-1:0] d;
    ins = q.pop_front();
    d   = ins[MA:1];
    r   = ref_alu(ins[MA+3 -: 3], mrb[ins[IW-1 -: RA]], mrb[ins[IW-1-RA -: RA]]);
    exp = (ins[0] || ins[MA+4]) ? r : mram[d];
    if (ins[0])    mram[d] = r;
    if (ins[MA+4]) mrb[d]  = r;
  endtask

  task automatic cycle(input bit vld, input logic [IW-1:0] ins, input bit ordy);
    logic [DW-1:0] e;
    @(negedge clk);
    in_valid  = vld;
    in_instr  = vld ? ins : IW'($urandom);
    out_ready = ordy;
    #1;
    cyc++;
    if (stall_prev) begin
      check_eq("hold_vld", DW'(out_valid), 1);
      check_eq("hold_dat", out_data, stall_data);
    end
    check_eq("in_ready", DW'(in_ready), DW'(q.size() < 2 || ordy));
    if (q.size() == 0) check_eq("idle_vld", DW'(out_valid), 0);
    if (out_valid && ordy && q.size() > 0) begin
      model_commit(e);
      check_eq("out_data", out_data, e);
      outs.push_back(out_data);
      fire_cyc = cyc;
    end
    stall_prev = out_valid && !ordy;
    stall_data = out_data;
    acc = vld && in_ready;
    if (acc) begin
      q.push_back(ins);
      acc_cyc = cyc;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
    check_eq("drain", DW'(q.size()), 0);
  endtask

  task automatic exp_out(input string tag, input int idx, input logic [DW-1:0] val);
    logic [DW-1:0] got;
    got = (idx < outs.size()) ? outs[idx] : 'x;
    check_eq(tag, got, val);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2;
    check_eq("rst_vld", DW'(out_valid), 0);
    check_eq("rst_dat", out_data, 0);
    check_eq("rst_rdy", DW'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Write RAM[3] = 2+7, check latency, read it back.
    outs.delete();
    cycle(1'b1, mk(2, 7, 0, 0, 3, 1), 1'b1);
    drain();
    check_eq("latency", DW'(fire_cyc - acc_cyc), 2);
    cycle(1'b1, mk(0, 0, 0, 0, 3, 0), 1'b1);
    drain();
    exp_out("t1_add", 0, 9);
    exp_out("t1_read", 1, 9);

    // Back-to-back register dependency, then read-backs.
    outs.delete();
    cycle(1'b1, mk(2, 3, 1, 0, 10, 0), 1'b1);
    cycle(1'b1, mk(10, 1, 0, 1, 4, 1), 1'b1);
    cycle(1'b1, mk(0, 0, 0, 0, 4, 0), 1'b1);
    cycle(1'b1, mk(10, 10, 1, 3, 10, 0), 1'b1);
    drain();
    exp_out("t2_add", 0, 5);
    exp_out("t2_sub", 1, 4);
    exp_out("t2_ram4", 2, 4);
    exp_out("t2_rb10", 3, 5);

    // RAM bypass.
    outs.delete();
    cycle(1'b1, mk(4, 5, 0, 4, 6, 1), 1'b1);
    cycle(1'b1, mk(0, 0, 0, 0, 6, 0), 1'b1);
    drain();
    exp_out("t3_xor", 0, 1);
    exp_out("t3_byp", 1, 1);

    // Backpressure with two dependent instructions in flight.
    outs.delete();
    cycle(1'b1, mk(8, 1, 1, 0, 8, 0), 1'b0);
    cycle(1'b1, mk(8, 1, 1, 0, 8, 0), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, mk(8, 8, 1, 3, 8, 0), 1'b0);
      check_eq("bp_rdy", DW'(in_ready), 0);
      check_eq("bp_acc", DW'(acc), 0);
    end
    drain();
    cycle(1'b1, mk(8, 8, 1, 3, 8, 0), 1'b1);
    drain();
    exp_out("t4_first", 0, 9);
    exp_out("t4_second", 1, 10);
    exp_out("t4_rb8", 2, 10);

    // Arithmetic edges, streamed back-to-back.
    outs.delete();
    cycle(1'b1, mk(0, 2, 1, 1, 12, 0), 1'b1);
    cycle(1'b1, mk(12, 1, 0, 5, 13, 1), 1'b1);
    cycle(1'b1, mk(16, 17, 1, 0, 15, 0), 1'b1);
    cycle(1'b1, mk(1, 15, 0, 6, 20, 1), 1'b1);
    cycle(1'b1, mk(12, 31, 0, 7, 21, 1), 1'b1);
    drain();
    exp_out("t5_sub", 0, 32'hFFFF_FFFE);
    exp_out("t5_slt", 1, 1);
    exp_out("t5_b33", 2, 33);
    exp_out("t5_shl", 3, 2);
    exp_out("t5_shr", 4, 1);

    // Random traffic, addresses often confined to a small window to provoke bypasses.
    for (int i = 0; i < 600; i++) begin
      int m;
      m = ($urandom_range(0, 1) == 0) ? 7 : 31;
      cycle($urandom_range(0, 3) != 0,
            mk($urandom & m, $urandom & m, $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom & m, $urandom_range(0, 1)),
            $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset with both stages occupied and stalled.
    cycle(1'b1, mk(5, 6, 0, 0, 7, 1), 1'b0);
    cycle(1'b1, mk(5, 6, 1, 0, 9, 0), 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", DW'(out_valid), 0);
    check_eq("mid_rst_dat", out_data, 0);
    check_eq("mid_rst_rdy", DW'(in_ready), 1);
    model_reset();
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    outs.delete();
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, mk(0, 0, 0, 0, i, 0), 1'b1);
      cycle(1'b1, mk(i, i, 1, 3, i, 0), 1'b1);
    end
    drain();
    for (int i = 0; i < 32; i++) begin
      exp_out("post_rst_ram", 2*i, 0);
      exp_out("post_rst_rb", 2*i + 1, DW'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
